// File: rtl/cnn_layer_ctrl_pkg.sv
// Shared constants for the CNN layer controller: defaults, state encodings
// and the start-state selection helper.
package cnn_layer_ctrl_pkg;

   // Default element width and the layer code that selects affine mode
   localparam int unsigned DATA_LEN_DEF    = 16;
   localparam logic [3:0]  AFFINE_CODE_DEF = 4'd5;

   // One-hot state encoding: each strobe is then a single flop bit
   localparam int unsigned NUM_STATES = 8;
   typedef logic [NUM_STATES-1:0] state_t;

   localparam int unsigned IdxIdle = 0;
   localparam int unsigned IdxZpad = 1;
   localparam int unsigned IdxIm2c = 2;
   localparam int unsigned IdxDotp = 3;
   localparam int unsigned IdxBias = 4;
   localparam int unsigned IdxAct  = 5;
   localparam int unsigned IdxFini = 6;
   localparam int unsigned IdxErr  = 7;

   localparam state_t StIdle = 8'b0000_0001;
   localparam state_t StZpad = 8'b0000_0010;
   localparam state_t StIm2c = 8'b0000_0100;
   localparam state_t StDotp = 8'b0000_1000;
   localparam state_t StBias = 8'b0001_0000;
   localparam state_t StAct  = 8'b0010_0000;
   localparam state_t StFini = 8'b0100_0000;
   localparam state_t StErr  = 8'b1000_0000;

   // Affine layers have no spatial unrolling, so they go straight to the dot product
   function automatic state_t first_state(input logic [3:0] cs, input logic [3:0] affine_code);
      return (cs == affine_code) ? StDotp : StZpad;
   endfunction

endpackage

// File: rtl/relu_lane.sv
// Single-lane signed clamp: negative values become zero when enabled.
module relu_lane
   import cnn_layer_ctrl_pkg::*;
#(
   parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
   input  logic [DATA_LEN-1:0] din,
   input  logic                en,
   output logic [DATA_LEN-1:0] dout
);

   // Sign bit alone decides; no width growth or saturation
   always_comb begin
      dout = din;
      if (en && din[DATA_LEN-1]) begin
         dout = '0;
      end
   end

endmodule

// File: rtl/cnn_layer_ctrl.sv
// CNN layer sequencer: steps zero-pad, im2col, dot product, bias and
// activation, then holds the activated result until the consumer takes it.
module cnn_layer_ctrl
   import cnn_layer_ctrl_pkg::*;
#(
   parameter int unsigned DATA_LEN    = DATA_LEN_DEF,
   parameter int unsigned CH_OUT      = 32,
   parameter int unsigned N_PIX       = 12,
   parameter logic [3:0]  AFFINE_CODE = AFFINE_CODE_DEF,
   parameter int unsigned DOT_TIMEOUT = 1024
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              load,
   input  logic [3:0]                        cs_layer,
   input  logic                              relu_en,
   input  logic                              dot_valid,
   input  logic [CH_OUT*N_PIX*DATA_LEN-1:0] d_bias,
   input  logic                              ready,
   output logic                              zpad_load,
   output logic                              im2c_load,
   output logic                              dot_load,
   output logic                              bias_load,
   output logic                              busy,
   output logic                              valid,
   output logic                              err,
   output logic [CH_OUT*N_PIX*DATA_LEN-1:0] q
);

   localparam int unsigned LANES = CH_OUT * N_PIX;
   localparam int unsigned W     = LANES * DATA_LEN;
   localparam int unsigned CNT_W = (DOT_TIMEOUT > 1) ? $clog2(DOT_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DOT_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [3:0]       cs_q, cs_d;
   logic             relu_q, relu_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     q_q;
   logic [W-1:0]     relu_out;
   logic             start;

   // A new layer may start from idle, from error, or from a result the consumer accepts
   always_comb begin
      start = 1'b0;
      if (load) begin
         start = state_q[IdxIdle] | state_q[IdxErr] | (state_q[IdxFini] & ready);
      end
   end

   // Next-state, capture registers and dot-product watchdog
   always_comb begin
      state_d = state_q;
      cs_d    = cs_q;
      relu_d  = relu_q;
      cnt_d   = '0;
      unique case (state_q)
         StIdle: ;
         StZpad: state_d = StIm2c;
         StIm2c: state_d = StDotp;
         StDotp: begin
            if (dot_valid) begin
               state_d = StBias;
            end else if (cnt_q == CNT_MAX) begin
               state_d = StErr;
            end else begin
               state_d = StDotp;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         StBias: state_d = StAct;
         StAct:  state_d = StFini;
         StFini: begin
            if (ready) begin
               state_d = StIdle;
            end
         end
         StErr: ;
         default: state_d = StIdle;
      endcase
      // Start overrides the per-state decision in idle, error and accepted fini
      if (start) begin
         state_d = first_state(cs_layer, AFFINE_CODE);
         cs_d    = cs_layer;
         relu_d  = relu_en;
         cnt_d   = '0;
      end
   end

   // Controller state and captured layer configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cs_q    <= '0;
         relu_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         relu_q  <= relu_d;
         cnt_q   <= cnt_d;
      end
   end

   // Per-lane activation of the bias result
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      relu_lane #(
         .DATA_LEN(DATA_LEN)
      ) u_relu (
         .din (d_bias[i*DATA_LEN +: DATA_LEN]),
         .en  (relu_q),
         .dout(relu_out[i*DATA_LEN +: DATA_LEN])
      );
   end

   // Result register: written only while in ACT, held everywhere else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else if (state_q[IdxAct]) begin
         q_q <= relu_out;
      end
   end

   // Outputs are direct flop bits of the one-hot state
   always_comb begin
      zpad_load = state_q[IdxZpad];
      im2c_load = state_q[IdxIm2c];
      dot_load  = state_q[IdxDotp];
      bias_load = state_q[IdxBias];
      busy      = state_q[IdxZpad] | state_q[IdxIm2c] | state_q[IdxDotp] |
                  state_q[IdxBias] | state_q[IdxAct];
      valid     = state_q[IdxFini];
      err       = state_q[IdxErr];
      q         = q_q;
   end

endmodule

// File: doc/cnn_layer_ctrl.md
CNN_LAYER_CTRL -- requirements
Module: cnn_layer_ctrl

Interface
REQ-001 Parameter DATA_LEN, default 16: signed element width in bits.
REQ-002 Parameter CH_OUT, default 32: output channels.
REQ-003 Parameter N_PIX, default 12: output pixels per channel.
REQ-004 Parameter AFFINE_CODE, default 4'd5: cs_layer value that selects affine mode.
REQ-005 Parameter DOT_TIMEOUT, default 1024: maximum DOTP cycles before error.
REQ-006 Port list (name, direction, width, meaning):
- clk, input, 1: single clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- load, input, 1: start request.
- cs_layer, input, 4: layer code, captured at start.
- relu_en, input, 1: activation enable, captured at start.
- dot_valid, input, 1: dot-product stage done.
- d_bias, input, CH_OUT*N_PIX*DATA_LEN: add_bias result.
- ready, input, 1: consumer accepts q.
- zpad_load, im2c_load, dot_load, bias_load, output, 1 each: stage strobes.
- busy, output, 1: layer in progress.
- valid, output, 1: q holds a valid result.
- err, output, 1: dot stage timed out.
- q, output, CH_OUT*N_PIX*DATA_LEN: registered activation result.

Function
REQ-007 States: IDLE, ZPAD, IM2C, DOTP, BIAS, ACT, FINI, ERR; one-hot or binary encoding is free.
REQ-008 Start condition: load=1 in IDLE, or load=1 with ready=1 in FINI.
- The start edge captures cs_layer and relu_en into internal registers.
- Next state: DOTP if cs_layer==AFFINE_CODE, else ZPAD.
REQ-009 ZPAD lasts 1 cycle and goes to IM2C; IM2C lasts 1 cycle and goes to DOTP.
REQ-010 DOTP holds until dot_valid=1 is sampled, then goes to BIAS; BIAS lasts 1 cycle and goes to ACT; ACT lasts 1 cycle and goes to FINI.
REQ-011 Each strobe is a decode of the current state:
- zpad_load=(ZPAD), im2c_load=(IM2C), dot_load=(DOTP), bias_load=(BIAS).
- Each is level-true for the whole state and never glitches across states.
REQ-012 ACT edge updates q for every lane i (CH_OUT*N_PIX lanes):
- lane value is signed d_bias[i]; if captured relu_en=1 and lane is negative, write 0, else write d_bias[i] unchanged.
- No width growth and no saturation.
REQ-013 q changes only on the ACT edge and holds otherwise, including through ERR.
REQ-014 valid=1 exactly in FINI; FINI holds until ready=1.
- ready=1 with load=0: go to IDLE.
- ready=1 with load=1: start the next layer per REQ-008 (back-to-back, no IDLE cycle).
REQ-015 busy=1 in every state except IDLE, FINI and ERR.
REQ-016 load is ignored when busy=1; cs_layer and relu_en changes while busy have no effect.
REQ-017 Timeout counter:
- clears on DOTP entry and increments each DOTP cycle with dot_valid=0.
- reaching DOT_TIMEOUT-1 with dot_valid=0 enters ERR.
- dot_valid=1 in the same cycle wins and goes to BIAS.
REQ-018 ERR: err=1 and all strobes 0; load=1 clears err and starts a new layer per REQ-008 capture rules.
REQ-019 Latency, non-affine: load sampled at edge 0 gives ZPAD in cycle 1, DOTP from cycle 3.
- dot_valid sampled at edge k gives BIAS in cycle k+1, ACT in k+2, valid=1 from cycle k+3.
- Affine mode skips ZPAD and IM2C, so DOTP starts in cycle 1.
REQ-020 ready in any state other than FINI is ignored.

Reset
REQ-021 rst_n=0 asynchronously forces:
- state IDLE, q=0, valid=0, busy=0, err=0, all strobes 0;
- timeout counter=0, captured cs_layer=0, captured relu_en=0.
REQ-022 Reset mid-layer abandons the layer with no valid pulse; the first start after release is accepted normally.

Structure
REQ-023 State encodings, AFFINE_CODE default and DATA_LEN default live in the shared data/constants include beside the existing state and num definitions.
REQ-024 One sub-module, relu_lane: a single-lane combinational signed clamp, instantiated CH_OUT*N_PIX times by generate; all registers stay in cnn_layer_ctrl.

Verification
REQ-025 Non-affine run: load at cycle 0, dot_valid at cycle 6 → zpad_load@1, im2c_load@2, dot_load@3-6, bias_load@7, valid from cycle 9.
REQ-026 Affine run (cs_layer=AFFINE_CODE): load at cycle 0 → dot_load from cycle 1, zpad_load and im2c_load never asserted.
REQ-027 ReLU: relu_en=1, lanes {-3, 0, 7, -32768} → q lanes {0, 0, 7, 0}; same input with relu_en=0 → q equals d_bias exactly.
REQ-028 Timeout: DOT_TIMEOUT=8, dot_valid held 0 → err=1 after 8 DOTP cycles, q unchanged; then load=1 → new run proceeds and err=0.
REQ-029 Back-to-back: in FINI, ready=1 and load=1 in the same cycle → next cycle is ZPAD; load while busy is ignored, no extra run occurs.
REQ-030 Reset: rst_n=0 asserted during DOTP → all outputs 0 immediately, without waiting for a clock edge; after release, load starts a clean run.
